// File: rtl/node_mem_arbiter_pkg.sv
// Shared node-memory definitions: geometry, arbiter state encoding and the
// byte-address map used by the routing-learning engines.
package node_mem_pkg;

    localparam int MEM_DEPTH  = 2048;
    localparam int MEM_WIDTH  = 8;
    localparam int WORD_WIDTH = 16;
    localparam int ADDR_W     = 11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        FLUSH = 2'd2
    } arb_state_e;

    localparam logic [ADDR_W-1:0] EPSILON          = 11'h004;
    localparam logic [ADDR_W-1:0] KNOWN_SINKS      = 11'h008;
    localparam logic [ADDR_W-1:0] NEIGHBOR_ID      = 11'h048;
    localparam logic [ADDR_W-1:0] CLUSTER_ID       = 11'h0C8;
    localparam logic [ADDR_W-1:0] BATTERY          = 11'h148;
    localparam logic [ADDR_W-1:0] QVALUE           = 11'h1C8;
    localparam logic [ADDR_W-1:0] SINK_IDS         = 11'h248;
    localparam logic [ADDR_W-1:0] KNOWN_SINK_COUNT = 11'h688;
    localparam logic [ADDR_W-1:0] NEIGHBOR_COUNT   = 11'h68A;
    localparam logic [ADDR_W-1:0] SINK_ID_COUNT    = 11'h68E;

endpackage

// File: rtl/node_mem_arbiter_if.sv
// Requester/memory bundle between the engines and the node-memory arbiter.
// master = engine side, slave = arbiter side.
interface node_mem_arbiter_if #(
    parameter int NREQ   = 3,
    parameter int ADDR_W = 11,
    parameter int WORD_W = 16
) ();
    logic [NREQ-1:0]        req;
    logic [NREQ-1:0]        rel;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ-1:0]        req_wr_en;
    logic [NREQ*WORD_W-1:0] req_wdata;
    logic [NREQ-1:0]        gnt;
    logic [ADDR_W-1:0]      mem_addr;
    logic                   mem_wr_en;
    logic [WORD_W-1:0]      mem_wdata;
    logic                   busy;
    logic [1:0]             owner;
    logic                   timeout_err;

    modport master (
        output req, rel, req_addr, req_wr_en, req_wdata,
        input  gnt, mem_addr, mem_wr_en, mem_wdata, busy, owner, timeout_err
    );

    modport slave (
        input  req, rel, req_addr, req_wr_en, req_wdata,
        output gnt, mem_addr, mem_wr_en, mem_wdata, busy, owner, timeout_err
    );
endinterface

// File: rtl/node_mem_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit searching upward from
// last_owner+1, wrapping modulo NREQ.
module rr_pick #(
    parameter int NREQ = 3
) (
    input  logic [NREQ-1:0] req,
    input  logic [1:0]      last_owner,
    output logic            valid,
    output logic [1:0]      pick
);
    localparam int unsigned N = NREQ;

    always_comb begin
        valid = 1'b0;
        pick  = '0;
        // Offset 1..N from last_owner; the last owner itself is visited last.
        for (int unsigned k = 1; k <= N; k++) begin
            for (int unsigned j = 0; j < N; j++) begin
                if (!valid && req[j] && (j == ((32'(last_owner) + k) % N))) begin
                    valid = 1'b1;
                    pick  = 2'(j);
                end
            end
        end
    end
endmodule

// File: rtl/node_mem_arbiter.sv
// Round-robin owner arbiter for the single-port node memory; the owner's
// address/write signals are muxed onto the port only while in GRANT.
module node_mem_arbiter #(
    parameter int NREQ     = 3,
    parameter int ADDR_W   = 11,
    parameter int WORD_W   = 16,
    parameter int MAX_HOLD = 0
) (
    input logic              clock,
    input logic              nrst,
    node_mem_arbiter_if.slave bus
);
    import node_mem_pkg::*;

    arb_state_e        state_q, state_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [NREQ-1:0]   rel_q, rel_edge;
    logic [1:0]        owner_q, owner_d;
    logic [1:0]        last_q, last_d;
    logic [15:0]       hold_q, hold_d;
    logic              tmo_q, tmo_d;

    logic              pick_valid;
    logic [1:0]        pick;
    logic              own_req, own_edge, own_we;
    logic [ADDR_W-1:0] own_addr;
    logic [WORD_W-1:0] own_wdata;
    logic              timeout_hit;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_wdata;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req       (bus.req),
        .last_owner(last_q),
        .valid     (pick_valid),
        .pick      (pick)
    );

    // A done level left over from a previous job must not release a fresh grant.
    assign rel_edge    = bus.rel & ~rel_q;
    assign timeout_hit = (MAX_HOLD != 0) && (hold_q == 16'(MAX_HOLD - 1));

    always_comb begin
        own_req   = 1'b0;
        own_edge  = 1'b0;
        own_we    = 1'b0;
        own_addr  = '0;
        own_wdata = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (owner_q == 2'(i)) begin
                own_req   = bus.req[i];
                own_edge  = rel_edge[i];
                own_we    = bus.req_wr_en[i];
                own_addr  = bus.req_addr[i*ADDR_W +: ADDR_W];
                own_wdata = bus.req_wdata[i*WORD_W +: WORD_W];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        owner_d   = owner_q;
        last_d    = last_q;
        hold_d    = hold_q;
        tmo_d     = tmo_q;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state_q)
            GRANT: begin
                mem_we    = own_we;
                mem_addr  = own_addr;
                mem_wdata = own_wdata;
                hold_d    = (hold_q == 16'hFFFF) ? hold_q : hold_q + 16'd1;
                if (own_edge || !own_req || timeout_hit) begin
                    state_d = FLUSH;
                    gnt_d   = '0;
                    if (timeout_hit) tmo_d = 1'b1;
                end
            end
            default: begin
                if (pick_valid) begin
                    state_d = GRANT;
                    for (int unsigned i = 0; i < NREQ; i++) gnt_d[i] = (pick == 2'(i));
                    owner_d = pick;
                    last_d  = pick;
                    hold_d  = '0;
                end else begin
                    state_d = IDLE;
                    gnt_d   = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!nrst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            owner_q <= '0;
            last_q  <= 2'(NREQ - 1);
            hold_q  <= '0;
            tmo_q   <= 1'b0;
            rel_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
            tmo_q   <= tmo_d;
            rel_q   <= bus.rel;
        end
    end

    assign bus.gnt         = gnt_q;
    assign bus.busy        = (state_q == GRANT);
    assign bus.owner       = owner_q;
    assign bus.timeout_err = tmo_q;
    assign bus.mem_wr_en   = mem_we;
    assign bus.mem_addr    = mem_addr;
    assign bus.mem_wdata   = mem_wdata;
endmodule

// File: tb/tb_node_mem_arbiter.sv
// Directed bench for node_mem_arbiter: expected grant owners are queued as
// requests are driven and popped when a grant appears.
module tb_node_mem_arbiter;
    import node_mem_pkg::*;

    localparam int NREQ = 3;
    localparam int AW   = 11;
    localparam int WW   = 16;

    logic clock;
    logic nrst;
    int   checks = 0;
    int   errors = 0;
    int   exp_q[$];
    int   lat;
    int   e;
    int   n;

    node_mem_arbiter_if #(.NREQ(NREQ), .ADDR_W(AW), .WORD_W(WW)) bus ();
    node_mem_arbiter_if #(.NREQ(NREQ), .ADDR_W(AW), .WORD_W(WW)) bus_u ();

    node_mem_arbiter #(.NREQ(NREQ), .ADDR_W(AW), .WORD_W(WW), .MAX_HOLD(8)) dut (
        .clock(clock), .nrst(nrst), .bus(bus)
    );

    node_mem_arbiter #(.NREQ(NREQ), .ADDR_W(AW), .WORD_W(WW), .MAX_HOLD(0)) dut_u (
        .clock(clock), .nrst(nrst), .bus(bus_u)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for a grant, then compare it with the next queued owner.
    task automatic expect_grant(input string tag, output int l, output int ex);
        l  = 0;
        ex = 0;
        while (bus.gnt == '0 && l < 8) begin
            tick();
            l++;
        end
        if (exp_q.size() != 0) ex = exp_q.pop_front();
        check({tag, "_gnt"},   32'(bus.gnt),   32'(1) << ex);
        check({tag, "_owner"}, 32'(bus.owner), 32'(ex));
        check({tag, "_busy"},  32'(bus.busy),  32'd1);
    endtask

    initial begin
        nrst            = 1'b0;
        bus.req         = '0;
        bus.rel         = '0;
        bus.req_addr    = '0;
        bus.req_wr_en   = '0;
        bus.req_wdata   = '0;
        bus_u.req       = '0;
        bus_u.rel       = '0;
        bus_u.req_addr  = '0;
        bus_u.req_wr_en = '0;
        bus_u.req_wdata = '0;
        tick();
        tick();
        check("rst_gnt",   32'(bus.gnt),         32'd0);
        check("rst_busy",  32'(bus.busy),        32'd0);
        check("rst_owner", 32'(bus.owner),       32'd0);
        check("rst_tmo",   32'(bus.timeout_err), 32'd0);
        check("rst_we",    32'(bus.mem_wr_en),   32'd0);
        check("rst_addr",  32'(bus.mem_addr),    32'd0);
        nrst = 1'b1;

        // Single requester: one-cycle latency, owner's signals on the port.
        bus.req_addr[0*AW +: AW]  = NEIGHBOR_COUNT;
        bus.req_wdata[0*WW +: WW] = 16'h1234;
        bus.req_wr_en             = 3'b001;
        bus.req                   = 3'b001;
        exp_q.push_back(0);
        expect_grant("t1", lat, e);
        check("t1_lat",   32'(lat),           32'd1);
        check("t1_addr",  32'(bus.mem_addr),  32'h68A);
        check("t1_we",    32'(bus.mem_wr_en), 32'd1);
        check("t1_wdata", 32'(bus.mem_wdata), 32'h1234);

        // Non-owner writes and releases are ignored.
        bus.req_wr_en             = 3'b111;
        bus.req_wdata[1*WW +: WW] = 16'hBEEF;
        bus.req_wdata[2*WW +: WW] = 16'hBEEF;
        bus.req_addr[1*AW +: AW]  = QVALUE;
        bus.rel                   = 3'b110;
        #1;
        check("nonown_wdata", 32'(bus.mem_wdata), 32'h1234);
        check("nonown_addr",  32'(bus.mem_addr),  32'h68A);
        bus.req_wr_en = 3'b110;
        #1;
        check("nonown_we", 32'(bus.mem_wr_en), 32'd0);
        tick();
        check("nonown_rel", 32'(bus.gnt), 32'b001);
        bus.rel       = '0;
        bus.req_wr_en = 3'b111;
        bus.req       = '0;
        tick();
        check("t1_flush_gnt",  32'(bus.gnt),       32'd0);
        check("t1_flush_busy", 32'(bus.busy),      32'd0);
        check("t1_flush_we",   32'(bus.mem_wr_en), 32'd0);
        check("t1_flush_addr", 32'(bus.mem_addr),  32'd0);
        tick();

        // All three requesting: rotation from last owner 0 gives 1,2,0,1.
        bus.req = 3'b111;
        exp_q.push_back(1);
        exp_q.push_back(2);
        exp_q.push_back(0);
        exp_q.push_back(1);
        for (int k = 0; k < 4; k++) begin
            expect_grant("rot", lat, e);
            check("rot_lat", 32'(lat),           32'd1);
            check("rot_we",  32'(bus.mem_wr_en), 32'd1);
            repeat (4) tick();
            check("rot_held", 32'(bus.gnt), 32'(1) << e);
            bus.rel[e] = 1'b1;
            tick();
            check("rot_flush_gnt", 32'(bus.gnt),       32'd0);
            check("rot_flush_we",  32'(bus.mem_wr_en), 32'd0);
            bus.rel = '0;
            if (k == 3) bus.req = '0;
        end
        tick();

        // Stale release level from a previous job must not end the new grant.
        bus.rel = 3'b010;
        tick();
        bus.req = 3'b010;
        exp_q.push_back(1);
        expect_grant("stale", lat, e);
        repeat (3) tick();
        check("stale_hold", 32'(bus.gnt), 32'b010);
        bus.rel = '0;
        tick();
        check("stale_low", 32'(bus.gnt), 32'b010);
        bus.rel = 3'b010;
        tick();
        check("stale_edge", 32'(bus.gnt), 32'd0);
        bus.req = '0;
        bus.rel = '0;
        tick();

        // Forced release after 8 grant cycles; requester 2 takes over.
        bus.req = 3'b001;
        exp_q.push_back(0);
        expect_grant("tmo", lat, e);
        check("tmo_pre", 32'(bus.timeout_err), 32'd0);
        bus.req = 3'b101;
        n = 1;
        while (n < 20) begin
            tick();
            if (bus.gnt != 3'b001) break;
            n++;
        end
        check("tmo_len",   32'(n),               32'd8);
        check("tmo_flush", 32'(bus.gnt),         32'd0);
        check("tmo_err",   32'(bus.timeout_err), 32'd1);
        exp_q.push_back(2);
        expect_grant("tmo_next", lat, e);
        check("tmo_next_lat", 32'(lat), 32'd1);
        bus.req = '0;
        tick();
        tick();
        check("tmo_sticky", 32'(bus.timeout_err), 32'd1);

        // Reset while the owner is writing.
        bus.req_addr[1*AW +: AW] = SINK_IDS;
        bus.req_wr_en            = 3'b010;
        bus.req                  = 3'b010;
        exp_q.push_back(1);
        expect_grant("rmid", lat, e);
        check("rmid_we", 32'(bus.mem_wr_en), 32'd1);
        nrst = 1'b0;
        tick();
        check("rmid_gnt",   32'(bus.gnt),         32'd0);
        check("rmid_we0",   32'(bus.mem_wr_en),   32'd0);
        check("rmid_busy",  32'(bus.busy),        32'd0);
        check("rmid_owner", 32'(bus.owner),       32'd0);
        check("rmid_tmo",   32'(bus.timeout_err), 32'd0);
        nrst    = 1'b1;
        bus.req = 3'b111;
        exp_q.push_back(0);
        expect_grant("post_rst", lat, e);
        check("post_rst_lat", 32'(lat), 32'd1);
        bus.req = '0;
        tick();

        // Unlimited hold never times out.
        bus_u.req = 3'b001;
        repeat (20) tick();
        check("unl_gnt", 32'(bus_u.gnt),         32'b001);
        check("unl_tmo", 32'(bus_u.timeout_err), 32'd0);
        bus_u.req = '0;
        tick();
        check("unl_rel", 32'(bus_u.gnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
